// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window MAC and the weight loader
// bench: default geometry, accumulator width derivation, the window FSM state
// encoding and the MSB-first weight slice index helper.
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int KMAX         = 4;
    localparam int WEIGHT_WIDTH = 8;
    localparam int PIXEL_WIDTH  = 8;
    // One extra bit for the zero-extended pixel, plus growth for KMAX*KMAX terms.
    localparam int ACC_WIDTH    = WEIGHT_WIDTH + PIXEL_WIDTH + 1 + $clog2(KMAX * KMAX);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } conv_state_e;

    // Bit index of the most-significant bit of weight idx in a packed kernel
    // where weight 0 occupies the top WEIGHT_WIDTH bits.
    function automatic int weight_msb(input int idx, input int kmax, input int ww);
        return (kmax * kmax * ww) - 1 - (idx * ww);
    endfunction

endpackage

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Signed weight x unsigned pixel multiply-accumulate.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, clears the accumulator
//   clr     in   clear the accumulator on this edge (takes priority over en)
//   en      in   add weight*pixel into the accumulator on this edge
//   weight  in   signed two's-complement weight
//   pixel   in   unsigned pixel, zero-extended before the multiply
//   sum     out  accumulator plus the current product (combinational), so the
//                caller can latch the finished dot product on the last term
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int WEIGHT_WIDTH = conv_pkg::WEIGHT_WIDTH,
    parameter int PIXEL_WIDTH  = conv_pkg::PIXEL_WIDTH,
    parameter int ACC_WIDTH    = conv_pkg::ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic        [PIXEL_WIDTH-1:0]  pixel,
    output logic signed [ACC_WIDTH-1:0]    sum
);

    localparam int PROD_W = WEIGHT_WIDTH + PIXEL_WIDTH + 1;

    logic signed [PROD_W-1:0]    prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] acc_r;

    // Signed multiply with the pixel forced non-negative by a leading zero.
    always_comb begin
        prod_s     = weight * $signed({1'b0, pixel});
        prod_ext_s = ACC_WIDTH'(prod_s);
        sum        = acc_r + prod_ext_s;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (en) begin
            acc_r <= sum;
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// -----------------------------------------------------------------------------
// conv_window_mac
// Computes one signed dot product per KERNEL_SIZE x KERNEL_SIZE pixel window
// (one MAC per accepted pixel) against a snapshotted kernel and presents it on
// an AXI-Stream master that holds its data under backpressure.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   weights_in     in   packed kernel, weight i at [KW-1-i*WEIGHT_WIDTH -: WEIGHT_WIDTH]
//   weights_load   in   one-cycle pulse, weights_in valid
//   s_axis_tdata   in   pixel, row-major window order
//   s_axis_tvalid  in   pixel valid
//   s_axis_tready  out  pixel ready (high only while running a window)
//   s_axis_tlast   in   final-pixel marker, checked against the internal count
//   m_axis_tdata   out  signed window result
//   m_axis_tvalid  out  result valid
//   m_axis_tready  in   downstream accept
//   busy           out  window in progress (count != 0 or result draining)
//   tlast_err      out  sticky flag: tlast disagreed with the window count
//
// Build option CONV_WINDOW_MAC_RELU_EN: negative results are clamped to zero
// as they are latched into m_axis_tdata (the accumulator itself is unclamped).
// -----------------------------------------------------------------------------
module conv_window_mac #(
    parameter  int KERNEL_SIZE  = 4,
    parameter  int KMAX         = conv_pkg::KMAX,
    parameter  int WEIGHT_WIDTH = conv_pkg::WEIGHT_WIDTH,
    parameter  int PIXEL_WIDTH  = conv_pkg::PIXEL_WIDTH,
    localparam int ACC_WIDTH    = WEIGHT_WIDTH + PIXEL_WIDTH + 1 + $clog2(KMAX * KMAX)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [KMAX*KMAX*WEIGHT_WIDTH-1:0]    weights_in,
    input  logic                                 weights_load,
    input  logic [PIXEL_WIDTH-1:0]               s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic signed [ACC_WIDTH-1:0]          m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 busy,
    output logic                                 tlast_err
);

    import conv_pkg::*;

    localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int KW    = KMAX * KMAX * WEIGHT_WIDTH;
    localparam int CNT_W = $clog2(KMAX * KMAX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KK - 1);

    conv_state_e                 state_r;
    conv_state_e                 state_next_s;
    logic [CNT_W-1:0]            count_r;
    logic [CNT_W-1:0]            count_next_s;
    logic [KW-1:0]               kernel_r;
    logic [KW-1:0]               pending_kernel_r;
    logic [KW-1:0]               kernel_eff_s;
    logic                        kernel_we_s;
    logic                        pending_r;
    logic                        stash_s;
    logic                        apply_now_s;
    logic                        beat_s;
    logic                        last_s;
    logic                        drain_exit_s;
    logic signed [WEIGHT_WIDTH-1:0] weight_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic signed [ACC_WIDTH-1:0] result_s;
    logic signed [ACC_WIDTH-1:0] m_tdata_r;
    logic                        m_tvalid_r;
    logic                        tready_r;
    logic                        busy_r;
    logic                        tlast_err_r;

    assign s_axis_tready = tready_r;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign busy          = busy_r;
    assign tlast_err     = tlast_err_r;

    // Handshake and window position decode.
    always_comb begin
        beat_s       = s_axis_tvalid & tready_r;
        last_s       = (count_r == LAST_CNT);
        drain_exit_s = (state_r == DRAIN) & m_tvalid_r & m_axis_tready;
    end

    // Next-state logic and weight-load routing (immediate apply vs. pending).
    always_comb begin
        state_next_s = state_r;
        apply_now_s  = 1'b0;
        stash_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (weights_load) begin
                    state_next_s = RUN;
                    apply_now_s  = 1'b1;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            RUN: begin
                // Between windows the new kernel is safe to use at once;
                // mid-window it waits so the window finishes on the old one.
                if (weights_load) begin
                    if (count_r == {CNT_W{1'b0}}) begin
                        apply_now_s = 1'b1;
                    end else begin
                        stash_s = 1'b1;
                    end
                end else begin
                    apply_now_s = 1'b0;
                end
                if (beat_s && last_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                // A pulse landing on the exit edge is the newest kernel, so it
                // is applied directly and supersedes anything pending.
                if (drain_exit_s) begin
                    state_next_s = RUN;
                    apply_now_s  = weights_load;
                end else begin
                    state_next_s = DRAIN;
                    stash_s      = weights_load;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // Kernel seen by the MAC this cycle and whether it is committed.
    always_comb begin
        kernel_eff_s = kernel_r;
        kernel_we_s  = 1'b0;
        if (apply_now_s) begin
            kernel_eff_s = weights_in;
            kernel_we_s  = 1'b1;
        end else if (drain_exit_s && pending_r) begin
            kernel_eff_s = pending_kernel_r;
            kernel_we_s  = 1'b1;
        end else begin
            kernel_eff_s = kernel_r;
            kernel_we_s  = 1'b0;
        end
    end

    // Select w[count]; weight 0 is the most-significant slice.
    assign weight_s = WEIGHT_WIDTH'(kernel_eff_s >>
                      (weight_msb(int'(count_r), KMAX, WEIGHT_WIDTH) - (WEIGHT_WIDTH - 1)));

    // Window position counter; wraps only on the K*K-th beat, tlast is ignored.
    always_comb begin
        count_next_s = count_r;
        if (beat_s) begin
            if (last_s) begin
                count_next_s = {CNT_W{1'b0}};
            end else begin
                count_next_s = count_r + CNT_W'(1'b1);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Optional rectification of the finished result.
    always_comb begin
        result_s = sum_s;
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (sum_s[ACC_WIDTH-1]) begin
            result_s = {ACC_WIDTH{1'b0}};
        end else begin
            result_s = sum_s;
        end
`else
        result_s = sum_s;
`endif
    end

    mac_unit #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (beat_s & last_s),
        .en     (beat_s),
        .weight (weight_s),
        .pixel  (s_axis_tdata),
        .sum    (sum_s)
    );

    // FSM state, counter and status outputs (registered from next-state values).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= EMPTY;
            count_r  <= {CNT_W{1'b0}};
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            count_r  <= count_next_s;
            tready_r <= (state_next_s == RUN);
            busy_r   <= (count_next_s != {CNT_W{1'b0}}) || (state_next_s == DRAIN);
        end
    end

    // Active and pending kernel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_r         <= {KW{1'b0}};
            pending_kernel_r <= {KW{1'b0}};
            pending_r        <= 1'b0;
        end else begin
            if (kernel_we_s) begin
                kernel_r <= kernel_eff_s;
            end
            if (stash_s) begin
                pending_kernel_r <= weights_in;
                pending_r        <= 1'b1;
            end else if (drain_exit_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Result register: loaded on the last beat, held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata_r  <= {ACC_WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
        end else if (beat_s && last_s) begin
            m_tdata_r  <= result_s;
            m_tvalid_r <= 1'b1;
        end else if (drain_exit_s) begin
            m_tvalid_r <= 1'b0;
        end
    end

    // Sticky flag for tlast disagreeing with the internal window position.
    always_ff @(posedge clk) begin
        if (rst) begin
            tlast_err_r <= 1'b0;
        end else if (beat_s && (s_axis_tlast != last_s)) begin
            tlast_err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
module tb_conv_window_mac;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] weights_in;
    logic         wl[3];
    logic [7:0]   sdata[3];
    logic         svalid[3];
    logic         sready[3];
    logic         slast[3];
    logic [20:0]  mdata[3];
    logic         mvalid[3];
    logic         mready[3];
    logic         busy[3];
    logic         terr[3];

    int total = 0;
    int bad   = 0;
    logic signed [31:0] exp_q[3][$];
    int kern[16];
    int kold[16];
    int pix[16];

    always #5 clk = ~clk;

    conv_window_mac #(.KERNEL_SIZE(2)) u_k2 (
        .clk(clk), .rst(rst), .weights_in(weights_in), .weights_load(wl[0]),
        .s_axis_tdata(sdata[0]), .s_axis_tvalid(svalid[0]), .s_axis_tready(sready[0]),
        .s_axis_tlast(slast[0]), .m_axis_tdata(mdata[0]), .m_axis_tvalid(mvalid[0]),
        .m_axis_tready(mready[0]), .busy(busy[0]), .tlast_err(terr[0]));

    conv_window_mac #(.KERNEL_SIZE(3)) u_k3 (
        .clk(clk), .rst(rst), .weights_in(weights_in), .weights_load(wl[1]),
        .s_axis_tdata(sdata[1]), .s_axis_tvalid(svalid[1]), .s_axis_tready(sready[1]),
        .s_axis_tlast(slast[1]), .m_axis_tdata(mdata[1]), .m_axis_tvalid(mvalid[1]),
        .m_axis_tready(mready[1]), .busy(busy[1]), .tlast_err(terr[1]));

    conv_window_mac #(.KERNEL_SIZE(4)) u_k4 (
        .clk(clk), .rst(rst), .weights_in(weights_in), .weights_load(wl[2]),
        .s_axis_tdata(sdata[2]), .s_axis_tvalid(svalid[2]), .s_axis_tready(sready[2]),
        .s_axis_tlast(slast[2]), .m_axis_tdata(mdata[2]), .m_axis_tvalid(mvalid[2]),
        .m_axis_tready(mready[2]), .busy(busy[2]), .tlast_err(terr[2]));

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] pack(input int k[16]);
        logic [127:0] p;
        p = 128'd0;
        for (int i = 0; i < 16; i++) p = {p[119:0], 8'(k[i])};
        return p;
    endfunction

    // Reference dot product over the first n weights/pixels.
    task automatic push_exp(input int u, input int n, input int k[16]);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s += k[i] * pix[i];
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q[u].push_back(s);
    endtask

    task automatic load(input int u, input int k[16]);
        weights_in = pack(k);
        wl[u] = 1'b1;
        @(posedge clk); #1;
        wl[u] = 1'b0;
    endtask

    task automatic send_beat(input int u, input int p, input bit last, input bit ld);
        int n;
        n = 0;
        svalid[u] = 1'b1;
        sdata[u]  = 8'(p);
        slast[u]  = last;
        while (sready[u] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("tready_wait", sready[u], 1);
        wl[u] = ld;
        @(posedge clk); #1;
        wl[u]     = 1'b0;
        svalid[u] = 1'b0;
        slast[u]  = 1'b0;
    endtask

    task automatic send_window(input int u, input int n, input int last_at, input int load_at);
        for (int i = 0; i < n; i++) send_beat(u, pix[i], (i == last_at), (i == load_at));
    endtask

    // Called #1 after the last pixel handshake: result must already be valid.
    task automatic get_result(input int u, input string tag);
        logic signed [31:0] e;
        e = 32'sh7fffffff;
        check({tag, "_valid"}, mvalid[u], 1);
        if (exp_q[u].size() > 0) e = exp_q[u].pop_front();
        check({tag, "_data"}, $signed(mdata[u]), e);
        mready[u] = 1'b1;
        @(posedge clk); #1;
        mready[u] = 1'b0;
        check({tag, "_vclr"}, mvalid[u], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [31:0] held;
        rst = 1'b1;
        weights_in = 128'd0;
        for (int u = 0; u < 3; u++) begin
            wl[u] = 1'b0; sdata[u] = 8'd0; svalid[u] = 1'b0; slast[u] = 1'b0; mready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset state on all instances.
        for (int u = 0; u < 3; u++) begin
            check("rst_tready", sready[u], 0);
            check("rst_tvalid", mvalid[u], 0);
            check("rst_tdata", $signed(mdata[u]), 0);
            check("rst_busy", busy[u], 0);
            check("rst_terr", terr[u], 0);
        end

        // No weights yet: pixels are refused.
        svalid[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("empty_tready", sready[2], 0);
        end
        svalid[2] = 1'b0;

        // K=2 basic window; low bits of weights_in are garbage and must be ignored.
        for (int i = 0; i < 16; i++) kern[i] = -85;
        kern[0] = 1; kern[1] = 2; kern[2] = 3; kern[3] = 4;
        load(0, kern);
        check("k2_tready", sready[0], 1);
        pix[0] = 10; pix[1] = 20; pix[2] = 30; pix[3] = 40;
        push_exp(0, 4, kern);
        send_window(0, 4, 3, -1);
        check("k2_busy_drain", busy[0], 1);
        check("k2_drain_tready", sready[0], 0);
        get_result(0, "k2_basic");
        check("k2_terr", terr[0], 0);

        // K=4 worst-case negative: all weights -128, all pixels 255.
        for (int i = 0; i < 16; i++) begin kern[i] = -128; pix[i] = 255; end
        load(2, kern);
        push_exp(2, 16, kern);
        send_window(2, 16, 15, -1);
        held = exp_q[2][0];
        // Backpressure: result and handshake state frozen for 5 cycles.
        for (int c = 0; c < 5; c++) begin
            check("bp_tvalid", mvalid[2], 1);
            check("bp_tdata", $signed(mdata[2]), held);
            check("bp_tready", sready[2], 0);
            @(posedge clk); #1;
        end
        get_result(2, "k4_min");
        check("k4_restart_tready", sready[2], 1);

        // Back-to-back window with random signed weights and random pixels.
        for (int i = 0; i < 16; i++) begin
            kern[i] = int'($urandom_range(0, 255)) - 128;
            pix[i]  = int'($urandom_range(0, 255));
        end
        load(2, kern);
        push_exp(2, 16, kern);
        send_window(2, 16, 15, -1);
        get_result(2, "k4_rand");

        // Mid-window load on K=2: old weights finish the window, new ones follow.
        for (int i = 0; i < 16; i++) begin kold[i] = 2; kern[i] = 1; pix[i] = 1; end
        load(0, kold);
        push_exp(0, 4, kold);
        weights_in = pack(kern);
        send_window(0, 4, 3, 1);
        get_result(0, "pend_old");
        push_exp(0, 4, kern);
        send_window(0, 4, 3, -1);
        get_result(0, "pend_new");

        // Load coincident with the first beat: that beat already uses new w[0].
        kern[0] = 5;
        pix[0] = 2;
        weights_in = pack(kern);
        push_exp(0, 4, kern);
        send_window(0, 4, 3, 0);
        get_result(0, "load_at_beat0");

        // K=3: tlast on beat 1 (and missing on beat 9) sets a sticky error.
        for (int i = 0; i < 16; i++) kern[i] = 99;
        kern[0] = 1; kern[1] = -2; kern[2] = 3; kern[3] = -4; kern[4] = 5;
        kern[5] = -6; kern[6] = 7; kern[7] = -8; kern[8] = 9;
        for (int i = 0; i < 9; i++) pix[i] = i * 10 + 5;
        load(1, kern);
        push_exp(1, 9, kern);
        send_beat(1, pix[0], 1'b1, 1'b0);
        check("tlast_err_set", terr[1], 1);
        for (int i = 1; i < 9; i++) send_beat(1, pix[i], 1'b0, 1'b0);
        get_result(1, "k3_tlast");
        check("tlast_err_sticky", terr[1], 1);

        // K=4: reset at beat 5 abandons the window; a load in the reset cycle loses.
        for (int i = 0; i < 16; i++) pix[i] = 7;
        for (int i = 0; i < 5; i++) send_beat(2, pix[i], 1'b0, 1'b0);
        check("pre_rst_busy", busy[2], 1);
        rst = 1'b1;
        wl[2] = 1'b1;
        weights_in = pack(kern);
        @(posedge clk); #1;
        rst = 1'b0;
        wl[2] = 1'b0;
        check("abort_tready", sready[2], 0);
        check("abort_tvalid", mvalid[2], 0);
        check("abort_tdata", $signed(mdata[2]), 0);
        check("abort_busy", busy[2], 0);
        check("abort_terr_k3", terr[1], 0);
        svalid[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort_hold_tready", sready[2], 0);
            check("abort_no_result", mvalid[2], 0);
        end
        svalid[2] = 1'b0;

        // Fresh window after reload must not carry any of the aborted sum.
        for (int i = 0; i < 16; i++) begin kern[i] = i - 8; pix[i] = 16 * i + 3; end
        load(2, kern);
        push_exp(2, 16, kern);
        send_window(2, 16, 15, -1);
        get_result(2, "post_rst");

        for (int u = 0; u < 3; u++) check("queue_empty", exp_q[u].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
